ice_risc_mem_arb: RTL and testbench
===================================

# ice_risc_mem_arb

Parametrised memory-port arbiter placed between one or more bus masters of the ice-risc core (instruction fetch, load/store unit, debug) and the single shared memory interface. The memory side uses the core's existing port set (read address, write address/data/strobe, read data). The arbiter grants one master per transaction and serialises access. Read latency is generalised from a single wait bit to a configurable 0–7 cycle wait count, with per-channel response routing.

## Interface

Parameters:
- pChannels, 2, number of requester channels (1–4)
- pMemReadWait, 1, memory read latency in cycles (0–7); 0 means `iwReadData` is combinationally valid in the same cycle as `owReadAddr`

Ports:
- iwClk  input  1  clock; all state updates on rising edge
- iwnRst  input  1  reset, asynchronous, active-low
- iwReqValid  input  pChannels  per-channel request valid
- iwReqWrite  input  pChannels  per-channel: 1 = write, 0 = read
- iwReqAddr  input  32*pChannels  per-channel byte address; channel i at [32i+31:32i]
- iwReqWdata  input  32*pChannels  per-channel write data
- iwReqWstrb  input  4*pChannels  per-channel byte strobes (writes only)
- owReqReady  output  pChannels  one-hot grant; request accepted when valid & ready
- owRspValid  output  pChannels  one-hot read-response valid, one cycle
- owRspData  output  32  read data, shared by all channels; meaningful only with owRspValid
- owReadAddr  output  32  memory read address
- owWriteAddr  output  32  memory write address
- owWriteData  output  32  memory write data
- owWstrb  output  4  memory byte strobe; nonzero only in a write cycle
- iwReadData  input  32  memory read data

## Operation

- States: IDLE, WAIT.
- **IDLE**
  - Select one channel with `iwReqValid` set. Arbitration is round-robin, starting from the priority pointer `rPrio`.
  - Assert `owReqReady` for that channel only, in the same cycle (combinational).
  - Advance `rPrio` to (granted+1) mod pChannels. With no valid request, `rPrio` holds.
- **Granted write**
  - Drive `owWriteAddr`, `owWriteData` and `owWstrb` from the channel in that cycle.
  - Remain in IDLE; the next grant is possible in the following cycle.
  - `iwReqWstrb` of 0 is passed through unchanged, which produces a no-op write.
- **Granted read**
  - Drive `owReadAddr` combinationally from the channel.
  - Latch the address and channel index.
  - pMemReadWait = 0: assert `owRspValid[ch]` in the same cycle with `owRspData = iwReadData`; remain in IDLE.
  - pMemReadWait > 0: load 3-bit counter with pMemReadWait-1 and go to WAIT.
- **WAIT**
  - `owReadAddr` holds the latched address. All `owReqReady` bits are 0.
  - The counter decrements each cycle.
  - In the cycle where the counter is 0, assert `owRspValid[latched ch]` and set `owRspData = iwReadData`; return to IDLE next cycle.
- **Requester rules**
  - Hold `iwReqValid` and the request fields stable until ready.
  - After an accepted read, do not re-request before `owRspValid`.
- **Defaults**
  - `owWriteAddr`, `owWriteData`, `owWstrb` are 0 outside a granted-write cycle.
  - `owReadAddr` equals the latched address except in a granted-read cycle.
  - `owRspData` = `iwReadData` at all times; only `owRspValid` qualifies it.
- **Single channel (pChannels = 1):** `rPrio` is fixed at 0 and arbitration degenerates to pass-through.

## Timing

- Write latency: 0 cycles; the memory write is in the grant cycle.
- Read: grant in cycle T; response in cycle T+pMemReadWait.
- Next grant is possible at T+pMemReadWait+1 (T+1 when pMemReadWait = 0).
- Peak throughput: 1 write/cycle; 1 read per (pMemReadWait+1) cycles.
- Simultaneous requests: only one grant per cycle; the others wait with valid held.
- Request arriving during WAIT is not granted until IDLE.
- Reset values: state IDLE, `rPrio` 0, counter 0, latched address 0, latched channel 0.
  - Resulting outputs: `owReqReady` 0, `owRspValid` 0, `owReadAddr` 0, `owWriteAddr` 0, `owWriteData` 0, `owWstrb` 0.
- Reset asserted during WAIT: immediate return to IDLE. The pending response is discarded and `owRspValid` is never asserted for it.

## Configuration

- `ICE_RISC_MEMARB_FIXED_PRIO_EN` defined:
  - Fixed priority; the lowest-index valid channel always wins.
  - `rPrio` is not implemented.
- Undefined (default): round-robin arbitration as described above.

## Test plan

- pChannels=2, pMemReadWait=0: ch0 read 0x100, memory returns 0xDEADBEEF -> `owReqReady` = 2'b01, `owRspValid` = 2'b01, `owRspData` 0xDEADBEEF, all in the same cycle.
- pMemReadWait=3: ch1 read 0x200 at T -> `owReadAddr` 0x200 for T..T+3; `owRspValid` = 2'b10 only at T+3; ch0 write requested at T+1 is granted at T+4.
- Both channels writing continuously (addresses 0x10 and 0x20) -> grants alternate ch0, ch1, ch0 every cycle; `owWstrb` equals the granted channel's strobe; with `ICE_RISC_MEMARB_FIXED_PRIO_EN`, ch0 is granted every cycle.
- Idle cycle -> `owWstrb` 4'h0, `owWriteAddr`/`owWriteData` 0, `owReqReady` 0.
- pMemReadWait=5: read accepted, then `iwnRst` pulsed low at T+2 -> all outputs 0 immediately; no `owRspValid` at T+5; the next request after reset is granted normally.
- pChannels=1, pMemReadWait=7: back-to-back reads -> grants 8 cycles apart, each response exactly 7 cycles after its grant.

Source files
------------

// File: rtl/ice_risc_mem_arb.sv
// Shares one memory port among pChannels masters. Arbitration is round-robin, or fixed lowest-index-first when ICE_RISC_MEMARB_FIXED_PRIO_EN is defined.
// A write completes in its grant cycle. A read responds pMemReadWait cycles after its grant, and no other grant is issued until that response.
module ice_risc_mem_arb #(
    parameter int pChannels    = 2,
    parameter int pMemReadWait = 1
) (
    input  logic                    iwClk,
    input  logic                    iwnRst,
    input  logic [pChannels-1:0]    iwReqValid,
    input  logic [pChannels-1:0]    iwReqWrite,
    input  logic [32*pChannels-1:0] iwReqAddr,
    input  logic [32*pChannels-1:0] iwReqWdata,
    input  logic [4*pChannels-1:0]  iwReqWstrb,
    output logic [pChannels-1:0]    owReqReady,
    output logic [pChannels-1:0]    owRspValid,
    output logic [31:0]             owRspData,
    output logic [31:0]             owReadAddr,
    output logic [31:0]             owWriteAddr,
    output logic [31:0]             owWriteData,
    output logic [3:0]              owWstrb,
    input  logic [31:0]             iwReadData
);
    localparam int CW = (pChannels > 1) ? $clog2(pChannels) : 1;

    typedef enum logic {ST_IDLE, ST_WAIT} state_t;

    state_t        state, state_nxt;
    logic [2:0]    cnt, cnt_nxt;
    logic [31:0]   lat_addr;
    logic [CW-1:0] lat_ch;
    logic          grant_any;
    logic [CW-1:0] grant_idx;
    int            arb_c;
    int            gi;
    logic          sel_write;
    logic [31:0]   sel_addr;
    logic [31:0]   sel_wdata;
    logic [3:0]    sel_wstrb;
    logic          rd_grant;

`ifndef ICE_RISC_MEMARB_FIXED_PRIO_EN
    logic [CW-1:0] prio;
`endif

    // The search starts at the priority pointer, and the first valid channel found wins.
    always_comb begin
        grant_any = 1'b0;
        grant_idx = '0;
        arb_c     = 0;
        for (int k = 0; k < pChannels; k++) begin
`ifdef ICE_RISC_MEMARB_FIXED_PRIO_EN
            arb_c = k;
`else
            arb_c = (int'(prio) + k) % pChannels;
`endif
            if (!grant_any && iwReqValid[arb_c]) begin
                grant_any = 1'b1;
                grant_idx = CW'(arb_c);
            end
        end
        gi        = int'(grant_idx);
        sel_write = iwReqWrite[gi];
        sel_addr  = iwReqAddr[32*gi +: 32];
        sel_wdata = iwReqWdata[32*gi +: 32];
        sel_wstrb = iwReqWstrb[4*gi +: 4];
    end

    always_comb begin
        state_nxt   = state;
        cnt_nxt     = cnt;
        rd_grant    = 1'b0;
        owReqReady  = '0;
        owRspValid  = '0;
        owRspData   = iwReadData;
        owReadAddr  = lat_addr;
        owWriteAddr = '0;
        owWriteData = '0;
        owWstrb     = '0;
        case (state)
            ST_IDLE: begin
                if (grant_any) begin
                    owReqReady[gi] = 1'b1;
                    if (sel_write) begin
                        owWriteAddr = sel_addr;
                        owWriteData = sel_wdata;
                        owWstrb     = sel_wstrb;
                    end else begin
                        rd_grant   = 1'b1;
                        owReadAddr = sel_addr;
                        if (pMemReadWait == 0) begin
                            owRspValid[gi] = 1'b1;
                        end else begin
                            state_nxt = ST_WAIT;
                            cnt_nxt   = 3'(pMemReadWait - 1);
                        end
                    end
                end
            end
            ST_WAIT: begin
                if (cnt == 3'd0) begin
                    owRspValid[int'(lat_ch)] = 1'b1;
                    state_nxt                = ST_IDLE;
                end else begin
                    cnt_nxt = cnt - 3'd1;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge iwClk or negedge iwnRst) begin
        if (!iwnRst) begin
            state    <= ST_IDLE;
            cnt      <= '0;
            lat_addr <= '0;
            lat_ch   <= '0;
`ifndef ICE_RISC_MEMARB_FIXED_PRIO_EN
            prio     <= '0;
`endif
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            if (rd_grant) begin
                lat_addr <= sel_addr;
                lat_ch   <= grant_idx;
            end
`ifndef ICE_RISC_MEMARB_FIXED_PRIO_EN
            if (state == ST_IDLE && grant_any)
                prio <= CW'((gi + 1) % pChannels);
`endif
        end
    end
endmodule

// File: tb/tb_ice_risc_mem_arb.sv
// Bench for ice_risc_mem_arb with three configurations: 2ch/wait3, 2ch/wait0 and 1ch/wait7.
`timescale 1ns/1ps
module tb_ice_risc_mem_arb;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int total = 0;
    int bad   = 0;

    typedef struct {
        int          cyc;
        logic [1:0]  rdy;
        logic        wr;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
    } gexp_t;

    typedef struct {
        int          cyc;
        logic [1:0]  vec;
        logic [31:0] data;
    } rexp_t;

    gexp_t gq_a[$], gq_b[$], gq_c[$];
    rexp_t rq_a[$], rq_b[$], rq_c[$];

    logic        rst_a, rst_bc;
    // Instance A: two channels, three read wait cycles
    logic [1:0]  vld_a, wr_a, rdy_a, rsp_a;
    logic [63:0] addr_a, wdat_a;
    logic [7:0]  strb_a;
    logic [31:0] rdat_a, raddr_a, waddr_a, wdo_a, mem_a;
    logic [3:0]  wso_a;
    // Instance B: two channels, zero read wait cycles
    logic [1:0]  vld_b, wr_b, rdy_b, rsp_b;
    logic [63:0] addr_b, wdat_b;
    logic [7:0]  strb_b;
    logic [31:0] rdat_b, raddr_b, waddr_b, wdo_b, mem_b;
    logic [3:0]  wso_b;
    // Instance C: one channel, seven read wait cycles
    logic        vld_c, wr_c, rdy_c, rsp_c;
    logic [31:0] addr_c, wdat_c;
    logic [3:0]  strb_c;
    logic [31:0] rdat_c, raddr_c, waddr_c, wdo_c, mem_c;
    logic [3:0]  wso_c;

    assign mem_a = ~raddr_a;
    assign mem_b = raddr_b ^ 32'hDEAD_BFEF;
    assign mem_c = raddr_c + 32'h1000;

    ice_risc_mem_arb #(.pChannels(2), .pMemReadWait(3)) dut_a (
        .iwClk(clk), .iwnRst(rst_a), .iwReqValid(vld_a), .iwReqWrite(wr_a),
        .iwReqAddr(addr_a), .iwReqWdata(wdat_a), .iwReqWstrb(strb_a),
        .owReqReady(rdy_a), .owRspValid(rsp_a), .owRspData(rdat_a),
        .owReadAddr(raddr_a), .owWriteAddr(waddr_a), .owWriteData(wdo_a),
        .owWstrb(wso_a), .iwReadData(mem_a));

    ice_risc_mem_arb #(.pChannels(2), .pMemReadWait(0)) dut_b (
        .iwClk(clk), .iwnRst(rst_bc), .iwReqValid(vld_b), .iwReqWrite(wr_b),
        .iwReqAddr(addr_b), .iwReqWdata(wdat_b), .iwReqWstrb(strb_b),
        .owReqReady(rdy_b), .owRspValid(rsp_b), .owRspData(rdat_b),
        .owReadAddr(raddr_b), .owWriteAddr(waddr_b), .owWriteData(wdo_b),
        .owWstrb(wso_b), .iwReadData(mem_b));

    ice_risc_mem_arb #(.pChannels(1), .pMemReadWait(7)) dut_c (
        .iwClk(clk), .iwnRst(rst_bc), .iwReqValid(vld_c), .iwReqWrite(wr_c),
        .iwReqAddr(addr_c), .iwReqWdata(wdat_c), .iwReqWstrb(strb_c),
        .owReqReady(rdy_c), .owRspValid(rsp_c), .owRspData(rdat_c),
        .owReadAddr(raddr_c), .owWriteAddr(waddr_c), .owWriteData(wdo_c),
        .owWstrb(wso_c), .iwReadData(mem_c));

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic unexpected(input string name, input logic [1:0] act);
        total++;
        bad++;
        $display("FAIL %s: got %0h expected nothing queued (cycle %0d)", name, act, cyc);
    endtask

    function automatic gexp_t g(input int c, input logic [1:0] r, input logic w,
                                input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
        gexp_t e;
        e.cyc = c; e.rdy = r; e.wr = w; e.addr = a; e.wdata = d; e.wstrb = s;
        return e;
    endfunction

    function automatic rexp_t r(input int c, input logic [1:0] v, input logic [31:0] d);
        rexp_t e;
        e.cyc = c; e.vec = v; e.data = d;
        return e;
    endfunction

    task automatic grant_chk(input string n, input gexp_t e, input logic [1:0] rdy,
                             input logic [31:0] raddr, input logic [31:0] waddr,
                             input logic [31:0] wdata, input logic [3:0] wstrb);
        check({n, "_grant_cyc"}, cyc, e.cyc);
        check({n, "_grant_rdy"}, rdy, e.rdy);
        if (e.wr) begin
            check({n, "_waddr"}, waddr, e.addr);
            check({n, "_wdata"}, wdata, e.wdata);
            check({n, "_wstrb"}, wstrb, e.wstrb);
        end else begin
            check({n, "_raddr"}, raddr, e.addr);
            check({n, "_rd_wstrb"}, wstrb, 4'h0);
        end
    endtask

    task automatic rsp_chk(input string n, input rexp_t e, input logic [1:0] vec, input logic [31:0] data);
        check({n, "_rsp_cyc"}, cyc, e.cyc);
        check({n, "_rsp_vec"}, vec, e.vec);
        check({n, "_rsp_data"}, data, e.data);
    endtask

    task automatic idle_chk(input string n, input logic [31:0] waddr, input logic [31:0] wdata, input logic [3:0] wstrb);
        check({n, "_idle_wad"}, {waddr, wdata}, 64'h0);
        check({n, "_idle_wstrb"}, wstrb, 4'h0);
    endtask

    always @(negedge clk) begin
        if (rdy_a != 2'b00) begin
            if (gq_a.size() == 0) unexpected("a_grant", rdy_a);
            else grant_chk("a", gq_a.pop_front(), rdy_a, raddr_a, waddr_a, wdo_a, wso_a);
        end else idle_chk("a", waddr_a, wdo_a, wso_a);
        if (rsp_a != 2'b00) begin
            if (rq_a.size() == 0) unexpected("a_rsp", rsp_a);
            else rsp_chk("a", rq_a.pop_front(), rsp_a, rdat_a);
        end
    end

    always @(negedge clk) begin
        if (rdy_b != 2'b00) begin
            if (gq_b.size() == 0) unexpected("b_grant", rdy_b);
            else grant_chk("b", gq_b.pop_front(), rdy_b, raddr_b, waddr_b, wdo_b, wso_b);
        end else idle_chk("b", waddr_b, wdo_b, wso_b);
        if (rsp_b != 2'b00) begin
            if (rq_b.size() == 0) unexpected("b_rsp", rsp_b);
            else rsp_chk("b", rq_b.pop_front(), rsp_b, rdat_b);
        end
    end

    always @(negedge clk) begin
        if (rdy_c) begin
            if (gq_c.size() == 0) unexpected("c_grant", {1'b0, rdy_c});
            else grant_chk("c", gq_c.pop_front(), {1'b0, rdy_c}, raddr_c, waddr_c, wdo_c, wso_c);
        end else idle_chk("c", waddr_c, wdo_c, wso_c);
        if (rsp_c) begin
            if (rq_c.size() == 0) unexpected("c_rsp", {1'b0, rsp_c});
            else rsp_chk("c", rq_c.pop_front(), {1'b0, rsp_c}, rdat_c);
        end
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic req_a(input int ch, input logic w, input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
        vld_a[ch] = 1'b1;
        wr_a[ch] = w;
        addr_a[32*ch +: 32] = a;
        wdat_a[32*ch +: 32] = d;
        strb_a[4*ch +: 4] = s;
    endtask

    task automatic req_b(input int ch, input logic w, input logic [31:0] a);
        vld_b[ch] = 1'b1;
        wr_b[ch] = w;
        addr_b[32*ch +: 32] = a;
    endtask

    initial begin
        int t;
        vld_a = '0; wr_a = '0; addr_a = '0; wdat_a = '0; strb_a = '0;
        vld_b = '0; wr_b = '0; addr_b = '0; wdat_b = '0; strb_b = '0;
        vld_c = 1'b0; wr_c = 1'b0; addr_c = '0; wdat_c = '0; strb_c = '0;
        rst_a = 1'b1; rst_bc = 1'b1;
        #1;
        rst_a = 1'b0; rst_bc = 1'b0;
        tick; tick;
        check("a_rst_rdy", rdy_a, 2'b00);
        check("a_rst_rsp", rsp_a, 2'b00);
        check("a_rst_raddr", raddr_a, 32'h0);
        check("a_rst_waddr", waddr_a, 32'h0);
        check("a_rst_wdata", wdo_a, 32'h0);
        check("a_rst_wstrb", wso_a, 4'h0);
        check("c_rst_raddr", raddr_c, 32'h0);
        rst_a = 1'b1; rst_bc = 1'b1;
        tick;

        // ch1 read with three wait cycles; a ch0 write that arrives during WAIT is held off
        t = cyc;
        req_a(1, 1'b0, 32'h200, 32'h0, 4'h0);
        gq_a.push_back(g(t, 2'b10, 1'b0, 32'h200, 32'h0, 4'h0));
        rq_a.push_back(r(t + 3, 2'b10, 32'hFFFF_FDFF));
        tick;
        vld_a[1] = 1'b0;
        req_a(0, 1'b1, 32'h10, 32'h1111_1111, 4'hF);
        gq_a.push_back(g(t + 4, 2'b01, 1'b1, 32'h10, 32'h1111_1111, 4'hF));
        for (int i = 1; i <= 3; i++) begin
            check("a_raddr_hold", raddr_a, 32'h200);
            check("a_rdy_wait", rdy_a, 2'b00);
            tick;
        end
        tick;
        vld_a[0] = 1'b0;

        // lone ch1 write, after which the pointer points back at ch0
        t = cyc;
        req_a(1, 1'b1, 32'h20, 32'h2222_2222, 4'hC);
        gq_a.push_back(g(t, 2'b10, 1'b1, 32'h20, 32'h2222_2222, 4'hC));
        tick;
        vld_a[1] = 1'b0;

        // both channels writing every cycle
        req_a(0, 1'b1, 32'h10, 32'h1111_1111, 4'h3);
        req_a(1, 1'b1, 32'h20, 32'h2222_2222, 4'hC);
        for (int k = 0; k < 4; k++) begin
`ifdef ICE_RISC_MEMARB_FIXED_PRIO_EN
            gq_a.push_back(g(cyc, 2'b01, 1'b1, 32'h10, 32'h1111_1111, 4'h3));
`else
            if (k % 2 == 0) gq_a.push_back(g(cyc, 2'b01, 1'b1, 32'h10, 32'h1111_1111, 4'h3));
            else            gq_a.push_back(g(cyc, 2'b10, 1'b1, 32'h20, 32'h2222_2222, 4'hC));
`endif
            tick;
        end
        vld_a[0] = 1'b0;
`ifdef ICE_RISC_MEMARB_FIXED_PRIO_EN
        gq_a.push_back(g(cyc, 2'b10, 1'b1, 32'h20, 32'h2222_2222, 4'hC));
        tick;
`endif
        vld_a[1] = 1'b0;
        tick; tick;

        // zero strobe passes through as a no-op write
        t = cyc;
        req_a(0, 1'b1, 32'h30, 32'h3333_3333, 4'h0);
        gq_a.push_back(g(t, 2'b01, 1'b1, 32'h30, 32'h3333_3333, 4'h0));
        tick;
        vld_a[0] = 1'b0;
        tick;

        // reset in the middle of WAIT drops the pending response
        t = cyc;
        req_a(0, 1'b0, 32'h300, 32'h0, 4'h0);
        gq_a.push_back(g(t, 2'b01, 1'b0, 32'h300, 32'h0, 4'h0));
        tick;
        vld_a[0] = 1'b0;
        tick;
        rst_a = 1'b0;
        #1;
        check("a_rstw_raddr", raddr_a, 32'h0);
        check("a_rstw_rdy", rdy_a, 2'b00);
        check("a_rstw_rsp", rsp_a, 2'b00);
        check("a_rstw_wad", {waddr_a, wdo_a}, 64'h0);
        check("a_rstw_wstrb", wso_a, 4'h0);
        tick;
        rst_a = 1'b1;
        tick;

        // after reset the pointer is back at ch0
        t = cyc;
        req_a(0, 1'b0, 32'h400, 32'h0, 4'h0);
        req_a(1, 1'b0, 32'h500, 32'h0, 4'h0);
        gq_a.push_back(g(t, 2'b01, 1'b0, 32'h400, 32'h0, 4'h0));
        rq_a.push_back(r(t + 3, 2'b01, 32'hFFFF_FBFF));
        gq_a.push_back(g(t + 4, 2'b10, 1'b0, 32'h500, 32'h0, 4'h0));
        rq_a.push_back(r(t + 7, 2'b10, 32'hFFFF_FAFF));
        tick;
        vld_a[0] = 1'b0;
        repeat (3) tick;
        tick;
        vld_a[1] = 1'b0;
        repeat (4) tick;

        // zero-wait instance: response in the grant cycle, next grant the cycle after
        t = cyc;
        req_b(0, 1'b0, 32'h100);
        req_b(1, 1'b0, 32'h104);
        gq_b.push_back(g(t, 2'b01, 1'b0, 32'h100, 32'h0, 4'h0));
        rq_b.push_back(r(t, 2'b01, 32'hDEAD_BEEF));
        gq_b.push_back(g(t + 1, 2'b10, 1'b0, 32'h104, 32'h0, 4'h0));
        rq_b.push_back(r(t + 1, 2'b10, 32'hDEAD_BEEB));
        tick;
        vld_b[0] = 1'b0;
        tick;
        vld_b[1] = 1'b0;
        tick;

        // single channel, seven wait cycles, back-to-back reads
        t = cyc;
        vld_c = 1'b1; addr_c = 32'h40;
        gq_c.push_back(g(t, 2'b01, 1'b0, 32'h40, 32'h0, 4'h0));
        rq_c.push_back(r(t + 7, 2'b01, 32'h1040));
        tick;
        vld_c = 1'b0;
        repeat (6) tick;
        vld_c = 1'b1; addr_c = 32'h44;
        gq_c.push_back(g(t + 8, 2'b01, 1'b0, 32'h44, 32'h0, 4'h0));
        rq_c.push_back(r(t + 15, 2'b01, 32'h1044));
        tick; tick;
        vld_c = 1'b0;
        repeat (8) tick;

        repeat (3) tick;
        check("a_grants_left", gq_a.size(), 0);
        check("a_rsps_left", rq_a.size(), 0);
        check("b_grants_left", gq_b.size(), 0);
        check("b_rsps_left", rq_b.size(), 0);
        check("c_grants_left", gq_c.size(), 0);
        check("c_rsps_left", rq_c.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
